dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Single-port data-memory controller between CPU M-stage data bus and a word-only DMA/loader port.
//  Arbitrates the two requesters onto one sync-read RAM (1-cycle read latency, word write only).
//  Converts CPU byte-enable partial stores into read-modify-write. Stalls the CPU while its access is pending.
// PARAMETERS
//  DEPTH_LOG2   12  RAM depth in words (4096); byte address space = 4*2^DEPTH_LOG2
//  MAX_STREAK   4   consecutive CPU grants allowed while d_req pending before DMA is forced in
// PORTS
//  clk            in   1   single clock, all state on posedge
//  reset          in   1   synchronous, active-high
//  m_data_addr    in   32  CPU byte address (word = addr[DEPTH_LOG2+1:2])
//  m_data_wdata   in   32  CPU store data, already lane-aligned
//  m_data_byteen  in   4   CPU store byte enables; nonzero = write
//  m_data_re      in   1   CPU load request (ignored if byteen nonzero)
//  m_data_rdata   out  32  CPU load data
//  m_stall        out  1   hold CPU M stage; request inputs stable while high
//  d_req          in   1   DMA request, held until d_gnt
//  d_we           in   1   DMA write (full word)
//  d_addr         in   32  DMA byte address, word aligned
//  d_wdata        in   32  DMA write data
//  d_gnt          out  1   1-cycle pulse: DMA request accepted
//  d_rvalid       out  1   1-cycle pulse: d_rdata valid (cycle after d_gnt for reads)
//  d_rdata        out  32  DMA read data
//  ram_addr       out  DEPTH_LOG2  RAM word address
//  ram_we         out  1   RAM word write strobe
//  ram_wdata      out  32  RAM write word
//  ram_rdata      in   32  RAM read word, valid 1 cycle after address
//  oob_err        out  1   1-cycle pulse: completed access had addr[31:DEPTH_LOG2+2] != 0
// BEHAVIOUR
//  - Reset: state=IDLE, streak=0, hold regs=0; m_stall=d_gnt=d_rvalid=ram_we=oob_err=0, m_data_rdata=d_rdata=0.
//  - cpu_req = m_data_re | (|m_data_byteen). m_stall = cpu_req & ~cpu_done_this_cycle; forced 0 during reset.
//  - FSM states: IDLE, CPU_RD, CPU_RMW, DMA_RD.
//  - IDLE arbitration: CPU wins unless d_req & streak==MAX_STREAK. Winner is granted this cycle.
//  - CPU full store (byteen==4'hf): ram_we=1 in IDLE, no stall, stay IDLE.
//  - CPU partial store: IDLE drives addr, m_stall=1 -> CPU_RMW; ram_wdata = per-lane byteen ? wdata : ram_rdata,
//    ram_we=1, m_stall=0 -> IDLE. One stall cycle.
//  - CPU load: IDLE drives addr, m_stall=1 -> CPU_RD; m_data_rdata=ram_rdata, m_stall=0, captured into hold reg -> IDLE.
//    Outside completion cycle m_data_rdata = hold reg (last completed load).
//  - DMA write: IDLE, d_gnt=1, ram_we=1, stay IDLE. DMA read: IDLE, d_gnt=1 -> DMA_RD; d_rvalid=1, d_rdata=ram_rdata -> IDLE.
//    d_rdata holds last value otherwise. A CPU request arriving with DMA granted sees m_stall=1 until served.
//  - Streak: +1 per CPU grant while d_req=1 (saturates at MAX_STREAK); cleared on DMA grant or d_req=0.
//  - Out of range: write suppressed (ram_we=0), read returns 0, handshake/latency unchanged, oob_err pulses at completion.
//  - One RAM access per cycle; never ram_we in CPU_RD/DMA_RD. No back-to-back overlap: next grant only from IDLE.
//  - Reset mid-operation: pending RMW write dropped, state IDLE next cycle, no d_rvalid/oob_err emitted.
// STRUCTURE
//  - Package dm_bus_pkg: state enum, BYTEEN_FULL=4'hf, word-index width function, merge function.
//  - Sub-module dm_byte_merge: combinational lane merge (old word, new word, byteen) -> merged word.
//  - Remaining FSM, streak counter, hold registers, RAM muxing inline.
// TESTING
//  - Full store addr 0x10, data 0x11223344, byteen f -> same cycle ram_we=1, ram_addr=4, m_stall=0.
//  - RAM word4=0xAABBCCDD; sb byteen 4'b0010 wdata 0x00005500 -> 1 stall cycle, then write 0xAABB55DD.
//  - Load 0x10 after above -> m_stall 1 cycle, m_data_rdata=0xAABB55DD, held after completion.
//  - d_req held + CPU stores every cycle, MAX_STREAK=4 -> 4 CPU grants, then d_gnt, CPU stalled that cycle.
//  - DMA read 0x20 (word8=0xCAFEBABE) -> d_gnt, next cycle d_rvalid=1, d_rdata=0xCAFEBABE.
//  - Store to 0x0001_0000 -> no ram_we, oob_err pulse; reset asserted in CPU_RMW -> no write, IDLE, all outputs 0.

Source files
------------

// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
package dm_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    CPU_RMW = 2'd2,
    DMA_RD  = 2'd3
  } state_t;

  localparam logic [3:0] BYTEEN_FULL = 4'hf;

  function automatic int word_index_width(input int depth_log2);
    return depth_log2;
  endfunction

  // Take new_w lanes where be is set, old_w lanes elsewhere.
  function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/dm_port_arbiter_byte_merge.sv
// Combinational byte-lane merge for the read-modify-write path of partial CPU stores.
module dm_byte_merge
  import dm_bus_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  byteen,
  output logic [31:0] merged
);

  assign merged = merge_word(old_word, new_word, byteen);

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates CPU M-stage and DMA requests onto one sync-read RAM; partial CPU stores become RMW.
// CPU loads and partial stores stall one cycle; DMA reads return data the cycle after d_gnt.
module dm_port_arbiter
  import dm_bus_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int MAX_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           m_data_addr,
  input  logic [31:0]           m_data_wdata,
  input  logic [3:0]            m_data_byteen,
  input  logic                  m_data_re,
  output logic [31:0]           m_data_rdata,
  output logic                  m_stall,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  output logic                  ram_we,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic                  oob_err
);

  localparam int AW = word_index_width(DEPTH_LOG2);
  localparam int SW = $clog2(MAX_STREAK + 1);

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [31:0]   m_hold_q, d_hold_q;
  logic          d_oob_q;

  logic          cpu_req, cpu_wr, cpu_full, cpu_done;
  logic          m_oob, d_oob, dma_win, cpu_win;
  logic [31:0]   merged_word;

  dm_byte_merge u_merge (
    .old_word (ram_rdata),
    .new_word (m_data_wdata),
    .byteen   (m_data_byteen),
    .merged   (merged_word)
  );

  always_comb begin
    cpu_req  = m_data_re | (|m_data_byteen);
    cpu_wr   = |m_data_byteen;
    cpu_full = (m_data_byteen == BYTEEN_FULL);
    m_oob    = |(m_data_addr >> (DEPTH_LOG2 + 2));
    d_oob    = |(d_addr >> (DEPTH_LOG2 + 2));
    dma_win  = d_req & (streak_q == SW'(MAX_STREAK));
    cpu_win  = cpu_req & ~dma_win;

    state_d      = state_q;
    streak_d     = streak_q;
    ram_addr     = m_data_addr[AW+1:2];
    ram_we       = 1'b0;
    ram_wdata    = m_data_wdata;
    d_gnt        = 1'b0;
    d_rvalid     = 1'b0;
    oob_err      = 1'b0;
    cpu_done     = 1'b0;
    m_data_rdata = m_hold_q;
    d_rdata      = d_hold_q;

    case (state_q)
      IDLE: begin
        if (cpu_win) begin
          streak_d = streak_q + SW'(1);
          if (cpu_wr && cpu_full) begin
            ram_we   = ~m_oob;
            oob_err  = m_oob;
            cpu_done = 1'b1;
          end else if (cpu_wr) begin
            state_d = CPU_RMW;
          end else begin
            state_d = CPU_RD;
          end
        end else if (d_req) begin
          d_gnt     = 1'b1;
          streak_d  = '0;
          ram_addr  = d_addr[AW+1:2];
          ram_wdata = d_wdata;
          if (d_we) begin
            ram_we  = ~d_oob;
            oob_err = d_oob;
          end else begin
            state_d = DMA_RD;
          end
        end
      end
      CPU_RMW: begin
        ram_wdata = merged_word;
        ram_we    = ~m_oob;
        oob_err   = m_oob;
        cpu_done  = 1'b1;
        state_d   = IDLE;
      end
      CPU_RD: begin
        m_data_rdata = m_oob ? 32'h0 : ram_rdata;
        oob_err      = m_oob;
        cpu_done     = 1'b1;
        state_d      = IDLE;
      end
      DMA_RD: begin
        d_rvalid = 1'b1;
        d_rdata  = d_oob_q ? 32'h0 : ram_rdata;
        oob_err  = d_oob_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!d_req) streak_d = '0;

    m_stall = cpu_req & ~cpu_done;

    // Any in-flight completion is squashed while reset is high.
    if (reset) begin
      m_stall      = 1'b0;
      d_gnt        = 1'b0;
      d_rvalid     = 1'b0;
      ram_we       = 1'b0;
      oob_err      = 1'b0;
      m_data_rdata = 32'h0;
      d_rdata      = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      m_hold_q <= 32'h0;
      d_hold_q <= 32'h0;
      d_oob_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if (state_q == CPU_RD) m_hold_q <= m_data_rdata;
      if (d_rvalid) d_hold_q <= d_rdata;
      if (state_q == IDLE && d_gnt && !d_we) d_oob_q <= d_oob;
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed cycle-by-cycle bench for dm_port_arbiter with a behavioural sync-read RAM.
module tb_dm_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr, m_data_wdata, m_data_rdata;
  logic [3:0]  m_data_byteen;
  logic        m_data_re, m_stall;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [11:0] ram_addr;
  logic        ram_we, oob_err;
  logic [31:0] ram_wdata, ram_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.DEPTH_LOG2(12), .MAX_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_data_re(m_data_re),
    .m_data_rdata(m_data_rdata), .m_stall(m_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .oob_err(oob_err)
  );

  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        re;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        e_stall;
    logic        e_we;
    logic [11:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_gnt;
    logic        e_rv;
    logic        e_oob;
    logic [31:0] e_mrd;
    logic [31:0] e_drd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic re, logic [3:0] be, logic [31:0] addr, logic [31:0] wdata,
                              logic dq, logic dwe, logic [31:0] daddr, logic [31:0] dwdata,
                              logic e_stall, logic e_we, logic [11:0] e_addr, logic [31:0] e_wdata,
                              logic e_gnt, logic e_rv, logic e_oob,
                              logic [31:0] e_mrd, logic [31:0] e_drd);
    vec_t v;
    v.re = re; v.be = be; v.addr = addr; v.wdata = wdata;
    v.dq = dq; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata;
    v.e_stall = e_stall; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_oob = e_oob; v.e_mrd = e_mrd; v.e_drd = e_drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cpu(input logic re, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    m_data_re = re; m_data_byteen = be; m_data_addr = addr; m_data_wdata = wdata;
  endtask

  task automatic drive_dma(input logic dq, input logic dwe,
                           input logic [31:0] daddr, input logic [31:0] dwdata);
    d_req = dq; d_we = dwe; d_addr = daddr; d_wdata = dwdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    reset = 1'b1;
    drive_cpu(1'b1, 4'h0, 32'h10, 32'h0);
    drive_dma(1'b1, 1'b0, 32'h20, 32'h0);
    next_cycle();
    next_cycle();

    // Requests pending during reset must not leak onto any output.
    @(negedge clk);
    chk("rst_stall", {31'h0, m_stall}, 32'h0);
    chk("rst_gnt", {31'h0, d_gnt}, 32'h0);
    chk("rst_rvalid", {31'h0, d_rvalid}, 32'h0);
    chk("rst_we", {31'h0, ram_we}, 32'h0);
    chk("rst_oob", {31'h0, oob_err}, 32'h0);
    chk("rst_mrd", m_data_rdata, 32'h0);
    chk("rst_drd", d_rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    drive_dma(1'b0, 1'b0, 32'h0, 32'h0);

    //             re  be    addr          wdata          dq  dwe daddr         dwdata
    //             stl we  ram_addr  ram_wdata       gnt rv oob  m_rdata        d_rdata
    vecs.push_back(mk(0, 4'hf, 32'h10,       32'h11223344, 0, 0, 32'h0,        32'h0,
                      0, 1, 12'd4, 32'h11223344, 0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        1, 1, 32'h10,       32'hAABBCCDD,
                      0, 1, 12'd4, 32'hAABBCCDD, 1, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        1, 1, 32'h20,       32'hCAFEBABE,
                      0, 1, 12'd8, 32'hCAFEBABE, 1, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 4'h2, 32'h10,       32'h00005500, 0, 0, 32'h0,        32'h0,
                      1, 0, 12'd0, 32'h0,        0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 4'h2, 32'h10,       32'h00005500, 0, 0, 32'h0,        32'h0,
                      0, 1, 12'd4, 32'hAABB55DD, 0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 4'h0, 32'h10,       32'h0,        0, 0, 32'h0,        32'h0,
                      1, 0, 12'd0, 32'h0,        0, 0, 0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 4'h0, 32'h10,       32'h0,        0, 0, 32'h0,        32'h0,
                      0, 0, 12'd0, 32'h0,        0, 0, 0, 32'hAABB55DD, 32'h0));
    vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,
                      0, 0, 12'd0, 32'h0,        0, 0, 0, 32'hAABB55DD, 32'h0));
    vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        1, 0, 32'h20,       32'h0,
                      0, 0, 12'd0, 32'h0,        1, 0, 0, 32'hAABB55DD, 32'h0));
    vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,
                      0, 0, 12'd0, 32'h0,        0, 1, 0, 32'hAABB55DD, 32'hCAFEBABE));
    vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,
                      0, 0, 12'd0, 32'h0,        0, 0, 0, 32'hAABB55DD, 32'hCAFEBABE));
    vecs.push_back(mk(0, 4'hf, 32'h00010000, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,
                      0, 0, 12'd0, 32'h0,        0, 0, 1, 32'hAABB55DD, 32'hCAFEBABE));
    vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,
                      0, 0, 12'd0, 32'h0,        0, 0, 0, 32'hAABB55DD, 32'hCAFEBABE));
    vecs.push_back(mk(1, 4'h0, 32'h00010000, 32'h0,        0, 0, 32'h0,        32'h0,
                      1, 0, 12'd0, 32'h0,        0, 0, 0, 32'hAABB55DD, 32'hCAFEBABE));
    vecs.push_back(mk(1, 4'h0, 32'h00010000, 32'h0,        0, 0, 32'h0,        32'h0,
                      0, 0, 12'd0, 32'h0,        0, 0, 1, 32'h0,        32'hCAFEBABE));
    vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,
                      0, 0, 12'd0, 32'h0,        0, 0, 0, 32'h0,        32'hCAFEBABE));
    vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        1, 0, 32'h80000000, 32'h0,
                      0, 0, 12'd0, 32'h0,        1, 0, 0, 32'h0,        32'hCAFEBABE));
    vecs.push_back(mk(0, 4'h0, 32'h0,        32'h0,        0, 0, 32'h0,        32'h0,
                      0, 0, 12'd0, 32'h0,        0, 1, 1, 32'h0,        32'h0));

    foreach (vecs[i]) begin
      drive_cpu(vecs[i].re, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      drive_dma(vecs[i].dq, vecs[i].dwe, vecs[i].daddr, vecs[i].dwdata);
      @(negedge clk);
      chk($sformatf("v%0d_stall", i), {31'h0, m_stall}, {31'h0, vecs[i].e_stall});
      chk($sformatf("v%0d_we", i), {31'h0, ram_we}, {31'h0, vecs[i].e_we});
      if (vecs[i].e_we) begin
        chk($sformatf("v%0d_addr", i), {20'h0, ram_addr}, {20'h0, vecs[i].e_addr});
        chk($sformatf("v%0d_wdata", i), ram_wdata, vecs[i].e_wdata);
      end
      chk($sformatf("v%0d_gnt", i), {31'h0, d_gnt}, {31'h0, vecs[i].e_gnt});
      chk($sformatf("v%0d_rvalid", i), {31'h0, d_rvalid}, {31'h0, vecs[i].e_rv});
      chk($sformatf("v%0d_oob", i), {31'h0, oob_err}, {31'h0, vecs[i].e_oob});
      chk($sformatf("v%0d_mrd", i), m_data_rdata, vecs[i].e_mrd);
      chk($sformatf("v%0d_drd", i), d_rdata, vecs[i].e_drd);
      next_cycle();
    end
    drive_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    drive_dma(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();

    // Streak: DMA held against back-to-back CPU full stores gets in on the fifth cycle.
    drive_dma(1'b1, 1'b1, 32'h40, 32'h12345678);
    for (int c = 0; c < 5; c++) begin
      drive_cpu(1'b0, 4'hf, 32'h30, 32'h100 + c);
      @(negedge clk);
      if (c < 4) begin
        chk($sformatf("streak%0d_gnt", c), {31'h0, d_gnt}, 32'h0);
        chk($sformatf("streak%0d_stall", c), {31'h0, m_stall}, 32'h0);
        chk($sformatf("streak%0d_wdata", c), ram_wdata, 32'h100 + c);
      end else begin
        chk("streak_dma_gnt", {31'h0, d_gnt}, 32'h1);
        chk("streak_cpu_stall", {31'h0, m_stall}, 32'h1);
        chk("streak_dma_we", {31'h0, ram_we}, 32'h1);
        chk("streak_dma_addr", {20'h0, ram_addr}, 32'h10);
        chk("streak_dma_wdata", ram_wdata, 32'h12345678);
      end
      next_cycle();
    end
    drive_dma(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("streak_cpu_resume_stall", {31'h0, m_stall}, 32'h0);
    chk("streak_cpu_resume_we", {31'h0, ram_we}, 32'h1);
    chk("streak_cpu_resume_wdata", ram_wdata, 32'h104);
    next_cycle();

    // Reset while in CPU_RMW: the merge write is dropped and the FSM restarts in IDLE.
    drive_cpu(1'b0, 4'h1, 32'h10, 32'h000000EE);
    @(negedge clk);
    chk("rmw_rst_stall_pre", {31'h0, m_stall}, 32'h1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("rmw_rst_we", {31'h0, ram_we}, 32'h0);
    chk("rmw_rst_stall", {31'h0, m_stall}, 32'h0);
    chk("rmw_rst_oob", {31'h0, oob_err}, 32'h0);
    chk("rmw_rst_mrd", m_data_rdata, 32'h0);
    chk("rmw_rst_drd", d_rdata, 32'h0);
    next_cycle();
    reset = 1'b0;
    drive_cpu(1'b0, 4'hf, 32'h50, 32'h0BADF00D);
    @(negedge clk);
    chk("post_rst_idle_stall", {31'h0, m_stall}, 32'h0);
    chk("post_rst_idle_we", {31'h0, ram_we}, 32'h1);
    chk("post_rst_idle_addr", {20'h0, ram_addr}, 32'h14);
    next_cycle();
    drive_cpu(1'b1, 4'h0, 32'h10, 32'h0);
    @(negedge clk);
    chk("post_rst_ld_stall", {31'h0, m_stall}, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("post_rst_ld_data", m_data_rdata, 32'hAABB55DD);
    next_cycle();
    drive_cpu(1'b0, 4'h0, 32'h0, 32'h0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
